// File: rtl/anim_pkg.sv
// Shared types and constants for the animation tick scheduler and its lane dividers.
package anim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_RUN,
        ST_PAUSE
    } state_t;

    localparam int LANES = 4;

    // Lane i shifts once every (i+1) ticks.
    localparam logic [LANES-1:0][2:0] LANE_DIV = {3'd4, 3'd3, 3'd2, 3'd1};

    function automatic int term_for_level(
        input logic [1:0] lvl,
        input int         t0,
        input int         t1,
        input int         t2,
        input int         t3
    );
        case (lvl)
            2'd0:    return t0;
            2'd1:    return t1;
            2'd2:    return t2;
            default: return t3;
        endcase
    endfunction

endpackage

// File: rtl/anim_lane_divider.sv
// Per-lane tick divider: counts animation ticks modulo i_divisor and strobes on wrap.
module anim_lane_divider (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_tick,
    input  logic [2:0] i_divisor,
    output logic       o_strobe
);

    logic [1:0] r_cnt;
    logic       r_strobe;
    logic       w_wrap;

    assign w_wrap = ({1'b0, r_cnt} == (i_divisor - 3'd1));

    // i_tick is the scheduler's next-cycle tick, so the strobe lands on the tick cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= 2'd0;
            r_strobe <= 1'b0;
        end else if (i_clr) begin
            r_cnt    <= 2'd0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= i_tick && w_wrap;
            if (i_tick) begin
                r_cnt <= w_wrap ? 2'd0 : r_cnt + 2'd1;
            end
        end
    end

    assign o_strobe = r_strobe;

endmodule

// File: rtl/anim_tick_scheduler.sv
// Sequences the external speed counter and turns its terminal counts into
// animation ticks, a wrapping sprite-frame index and per-lane shift strobes.
module anim_tick_scheduler
    import anim_pkg::*;
#(
    parameter int DATAWIDTH = 24,
    parameter int FRAMES    = 4,
    parameter int TERM_L0   = 5000000,
    parameter int TERM_L1   = 3750000,
    parameter int TERM_L2   = 2500000,
    parameter int TERM_L3   = 1250000
) (
    input  logic                       SC_ANIMSCHED_CLOCK_50,
    input  logic                       SC_ANIMSCHED_RESET_InHigh,
    input  logic                       SC_ANIMSCHED_start_InHigh,
    input  logic                       SC_ANIMSCHED_stop_InHigh,
    input  logic                       SC_ANIMSCHED_pause_InHigh,
    input  logic [1:0]                 SC_ANIMSCHED_level_InBUS,
    input  logic [DATAWIDTH-1:0]       SC_ANIMSCHED_count_InBUS,
    output logic                       SC_ANIMSCHED_clear_OutLow,
    output logic                       SC_ANIMSCHED_upcount_OutLow,
    output logic                       SC_ANIMSCHED_tick_OutHigh,
    output logic [$clog2(FRAMES)-1:0]  SC_ANIMSCHED_frame_OutBUS,
    output logic [3:0]                 SC_ANIMSCHED_laneshift_OutBUS,
    output logic                       SC_ANIMSCHED_running_OutHigh
);

    localparam int FW = $clog2(FRAMES);

    state_t          r_state;
    logic [1:0]      r_level;
    logic [FW-1:0]   r_frame;
    logic            r_clear_n;
    logic            r_upcount_n;
    logic            r_tick;
    logic            r_running;

    logic [31:0]          w_term;
    logic [DATAWIDTH-1:0] w_run_match_val;
    logic [DATAWIDTH-1:0] w_resume_match_val;
    logic                 w_lvl_chg;
    logic                 w_tick_next;
    logic [FW-1:0]        w_frame_inc;
    logic [LANES-1:0]     w_strobe;

    assign w_term             = 32'(term_for_level(r_level, TERM_L0, TERM_L1, TERM_L2, TERM_L3));
    assign w_run_match_val    = DATAWIDTH'(w_term - 32'd2);
    assign w_resume_match_val = DATAWIDTH'(w_term - 32'd1);
    assign w_lvl_chg          = (SC_ANIMSCHED_level_InBUS != r_level);
    assign w_frame_inc        = (r_frame == FW'(FRAMES - 1)) ? '0 : r_frame + 1'b1;

    // The counter still advances on the cycle pause is first seen, so a match dropped
    // there is found one count higher on resume; ticking then keeps the remaining distance.
    assign w_tick_next = !SC_ANIMSCHED_stop_InHigh && !w_lvl_chg && !SC_ANIMSCHED_pause_InHigh &&
                         (((r_state == ST_RUN)   && (SC_ANIMSCHED_count_InBUS == w_run_match_val)) ||
                          ((r_state == ST_PAUSE) && (SC_ANIMSCHED_count_InBUS == w_resume_match_val)));

    always_ff @(posedge SC_ANIMSCHED_CLOCK_50 or posedge SC_ANIMSCHED_RESET_InHigh) begin
        if (SC_ANIMSCHED_RESET_InHigh) begin
            r_state     <= ST_IDLE;
            r_level     <= 2'd0;
            r_frame     <= '0;
            r_clear_n   <= 1'b0;
            r_upcount_n <= 1'b1;
            r_tick      <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_tick <= w_tick_next;
            if (SC_ANIMSCHED_stop_InHigh) begin
                r_state     <= ST_IDLE;
                r_frame     <= '0;
                r_clear_n   <= 1'b0;
                r_upcount_n <= 1'b1;
                r_running   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_clear_n   <= 1'b0;
                        r_upcount_n <= 1'b1;
                        r_running   <= 1'b0;
                        if (SC_ANIMSCHED_start_InHigh) begin
                            r_level <= SC_ANIMSCHED_level_InBUS;
                            r_state <= ST_FLUSH;
                        end
                    end
                    ST_FLUSH: begin
                        r_state     <= ST_RUN;
                        r_clear_n   <= 1'b1;
                        r_upcount_n <= 1'b0;
                        r_running   <= 1'b1;
                    end
                    ST_RUN, ST_PAUSE: begin
                        if (w_lvl_chg) begin
                            r_level     <= SC_ANIMSCHED_level_InBUS;
                            r_state     <= ST_FLUSH;
                            r_clear_n   <= 1'b0;
                            r_upcount_n <= 1'b1;
                            r_running   <= 1'b0;
                        end else if (SC_ANIMSCHED_pause_InHigh) begin
                            r_state     <= ST_PAUSE;
                            r_clear_n   <= 1'b1;
                            r_upcount_n <= 1'b1;
                            r_running   <= 1'b0;
                        end else begin
                            r_state     <= ST_RUN;
                            r_clear_n   <= !w_tick_next;
                            r_upcount_n <= 1'b0;
                            r_running   <= 1'b1;
                            if (w_tick_next) begin
                                r_frame <= w_frame_inc;
                            end
                        end
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_clear_n   <= 1'b0;
                        r_upcount_n <= 1'b1;
                        r_running   <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        anim_lane_divider u_div (
            .i_clk     (SC_ANIMSCHED_CLOCK_50),
            .i_rst     (SC_ANIMSCHED_RESET_InHigh),
            .i_clr     (SC_ANIMSCHED_stop_InHigh),
            .i_tick    (w_tick_next),
            .i_divisor (LANE_DIV[gi]),
            .o_strobe  (w_strobe[gi])
        );
    end

    assign SC_ANIMSCHED_clear_OutLow     = r_clear_n;
    assign SC_ANIMSCHED_upcount_OutLow   = r_upcount_n;
    assign SC_ANIMSCHED_tick_OutHigh     = r_tick;
    assign SC_ANIMSCHED_frame_OutBUS     = r_frame;
    assign SC_ANIMSCHED_laneshift_OutBUS = w_strobe;
    assign SC_ANIMSCHED_running_OutHigh  = r_running;

endmodule

// File: tb/tb_anim_tick_scheduler.sv
// Directed bench: stimulus pushes expected ticks (cycle, frame, lane strobes) into a
// scoreboard that a negedge monitor pops and compares; a simple up-counter stands in for the speed counter.
module tb_anim_tick_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        pause;
    logic [1:0]  level;
    logic [23:0] cnt = '0;
    logic        clear_n;
    logic        upcount_n;
    logic        tick;
    logic [1:0]  frame;
    logic [3:0]  ls;
    logic        running;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         cyc;
        logic [1:0] frame;
        logic [3:0] ls;
    } exp_t;

    exp_t sb[$];

    // Lane strobes for ticks 1..12 from a fresh start: bit i set when tick number % (i+1) == 0.
    logic [3:0] ls_tbl [12] = '{4'b0001, 4'b0011, 4'b0101, 4'b1011, 4'b0001, 4'b0111,
                                4'b0001, 4'b1011, 4'b0101, 4'b0011, 4'b0001, 4'b1111};

    anim_tick_scheduler #(
        .DATAWIDTH (24),
        .FRAMES    (4),
        .TERM_L0   (8),
        .TERM_L1   (6),
        .TERM_L2   (4),
        .TERM_L3   (3)
    ) dut (
        .SC_ANIMSCHED_CLOCK_50         (clk),
        .SC_ANIMSCHED_RESET_InHigh     (rst),
        .SC_ANIMSCHED_start_InHigh     (start),
        .SC_ANIMSCHED_stop_InHigh      (stop),
        .SC_ANIMSCHED_pause_InHigh     (pause),
        .SC_ANIMSCHED_level_InBUS      (level),
        .SC_ANIMSCHED_count_InBUS      (cnt),
        .SC_ANIMSCHED_clear_OutLow     (clear_n),
        .SC_ANIMSCHED_upcount_OutLow   (upcount_n),
        .SC_ANIMSCHED_tick_OutHigh     (tick),
        .SC_ANIMSCHED_frame_OutBUS     (frame),
        .SC_ANIMSCHED_laneshift_OutBUS (ls),
        .SC_ANIMSCHED_running_OutHigh  (running)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Speed counter: synchronous active-low clear, active-low count enable.
    always @(posedge clk) begin
        if (!clear_n)        cnt <= '0;
        else if (!upcount_n) cnt <= cnt + 24'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [1:0] f, input logic [3:0] l);
        exp_t e;
        e.cyc   = c;
        e.frame = f;
        e.ls    = l;
        sb.push_back(e);
    endtask

    // Returns 1 time unit after the posedge that brings cyc to c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (tick) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_tick: tick at cycle %0d, none expected", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("tick_cycle", cyc, e.cyc);
                    chk("tick_frame", frame, e.frame);
                    chk("tick_laneshift", ls, e.ls);
                    chk("tick_clear", clear_n, 1'b0);
                end
            end else begin
                chk("quiet_laneshift", ls, 4'b0000);
                if (running) chk("run_clear", clear_n, 1'b1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d ticks still expected", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, t0, t1, t2, u;
        rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; level = 2'd0;
        #2 rst = 1'b1;
        #1;
        chk("rst_clear", clear_n, 1'b0);
        chk("rst_upcount", upcount_n, 1'b1);
        chk("rst_tick", tick, 1'b0);
        chk("rst_frame", frame, 2'd0);
        chk("rst_laneshift", ls, 4'd0);
        chk("rst_running", running, 1'b0);
        goto(3);
        rst = 1'b0;

        // Level 0: FLUSH after s+1, RUN after s+2, first tick at s+9, then every 8.
        s = 5;
        goto(s);
        start = 1'b1;
        level = 2'd0;
        for (int j = 0; j < 12; j++) push(s + 9 + 8 * j, 2'((j + 1) % 4), ls_tbl[j]);
        goto(s + 1);
        start = 1'b0;
        chk("flush_clear", clear_n, 1'b0);
        chk("flush_upcount", upcount_n, 1'b1);
        chk("flush_running", running, 1'b0);
        goto(s + 2);
        chk("run_entry_running", running, 1'b1);
        chk("run_entry_upcount", upcount_n, 1'b0);
        chk("run_entry_count", cnt, 24'd0);

        // Pause seen while count is 3: counter advances once more, then freezes at 4.
        t0 = s + 97;
        goto(t0 + 4);
        chk("pre_pause_count", cnt, 24'd3);
        pause = 1'b1;
        push(t0 + 18, 2'd1, 4'b0001);
        goto(t0 + 10);
        chk("pause_count", cnt, 24'd4);
        chk("pause_upcount", upcount_n, 1'b1);
        chk("pause_running", running, 1'b0);
        goto(t0 + 14);
        pause = 1'b0;

        // Level change at count 5 (next count would match at level 0): no tick, then period 3.
        t1 = t0 + 18;
        goto(t1 + 6);
        chk("pre_lvl_count", cnt, 24'd5);
        level = 2'd3;
        push(t1 + 10, 2'd2, 4'b0011);
        push(t1 + 13, 2'd3, 4'b0101);
        push(t1 + 16, 2'd0, 4'b1011);
        goto(t1 + 8);
        chk("lvl_flush_count", cnt, 24'd0);
        chk("lvl_run_running", running, 1'b1);

        // Stop on the match cycle: tick suppressed, IDLE with frame 0 and clear low.
        t2 = t1 + 16;
        goto(t2 + 2);
        chk("pre_stop_count", cnt, 24'd1);
        stop = 1'b1;
        goto(t2 + 3);
        stop = 1'b0;
        chk("stop_tick", tick, 1'b0);
        chk("stop_frame", frame, 2'd0);
        chk("stop_clear", clear_n, 1'b0);
        chk("stop_running", running, 1'b0);
        chk("stop_upcount", upcount_n, 1'b1);

        // Restart at level 2: dividers and frame start over; a start while running is ignored.
        u = t2 + 6;
        goto(u);
        start = 1'b1;
        level = 2'd2;
        push(u + 5, 2'd1, 4'b0001);
        push(u + 9, 2'd2, 4'b0011);
        goto(u + 1);
        start = 1'b0;
        goto(u + 6);
        start = 1'b1;
        goto(u + 7);
        start = 1'b0;

        // Asynchronous reset between clock edges.
        goto(u + 10);
        #2;
        chk("pre_rst_frame", frame, 2'd2);
        chk("pre_rst_running", running, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_running", running, 1'b0);
        chk("async_rst_frame", frame, 2'd0);
        chk("async_rst_clear", clear_n, 1'b0);
        chk("async_rst_upcount", upcount_n, 1'b1);
        goto(u + 12);
        rst = 1'b0;
        goto(u + 15);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
